// File: rtl/card_hand_display.sv
// card_hand_display: registered baccarat hand store with per-slot 7-seg glyphs, running score and newest-card blink
module card_hand_display #(
    parameter int NUM_SLOTS = 3,
    parameter int BLINK_HALF = 4,
    localparam int CW = $clog2(NUM_SLOTS + 1),
    localparam int BW = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1
) (
    input  logic                   slow_clock,
    input  logic                   resetb,
    input  logic                   load,
    input  logic [3:0]             card_in,
    input  logic                   clear,
    input  logic                   blink_en,
    output logic [7*NUM_SLOTS-1:0] hex_out,
    output logic [3:0]             score,
    output logic [CW-1:0]          count,
    output logic                   full,
    output logic                   overflow,
    output logic                   invalid
);
    logic [3:0]    slot [NUM_SLOTS];
    logic [BW-1:0] blink_cnt;
    logic          blink_off;
    logic          bad, accept;
    logic [3:0]    val;
    logic [4:0]    sum;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'd1:    glyph = 7'b0001000;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            4'd10:   glyph = 7'b1000000;
            4'd11:   glyph = 7'b1100001;
            4'd12:   glyph = 7'b0011000;
            4'd13:   glyph = 7'b0001001;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    assign full   = count == CW'(NUM_SLOTS);
    assign bad    = card_in == 4'd0 || card_in > 4'd13;
    assign accept = load && !bad && !full;
    assign val    = card_in <= 4'd9 ? card_in : 4'd0;
    assign sum    = {1'b0, score} + {1'b0, val};

    always_ff @(posedge slow_clock) begin
        if (!resetb || clear) begin
            for (int i = 0; i < NUM_SLOTS; i++) slot[i] <= 4'd0;
            count     <= '0;
            score     <= 4'd0;
            overflow  <= 1'b0;
            invalid   <= 1'b0;
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else begin
            invalid  <= load && bad;
            overflow <= load && !bad && full;
            if (accept) begin
                for (int i = 0; i < NUM_SLOTS; i++)
                    if (count == CW'(i)) slot[i] <= card_in;
                count <= count + CW'(1);
                score <= sum >= 5'd10 ? 4'(sum - 5'd10) : sum[3:0];
            end
            // a fresh card restarts the blink so it is shown a full half-period first
            if (accept || !blink_en || count == '0) begin
                blink_cnt <= '0;
                blink_off <= 1'b0;
            end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                blink_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_hex
        assign hex_out[7*i +: 7] = (blink_en && blink_off && count == CW'(i + 1)) ? 7'b1111111 : glyph(slot[i]);
    end
endmodule

// File: tb/tb_card_hand_display.sv
// tb_card_hand_display: directed plus randomized checks against a queue-based hand model
module tb_card_hand_display;
    localparam int NS = 3;
    localparam int BH = 4;

    logic          slow_clock, resetb, load, clear, blink_en;
    logic [3:0]    card_in;
    logic [7*NS-1:0] hex_out;
    logic [3:0]    score;
    logic [1:0]    count;
    logic          full, overflow, invalid;

    card_hand_display #(.NUM_SLOTS(NS), .BLINK_HALF(BH)) dut (
        .slow_clock(slow_clock), .resetb(resetb), .load(load), .card_in(card_in),
        .clear(clear), .blink_en(blink_en), .hex_out(hex_out), .score(score),
        .count(count), .full(full), .overflow(overflow), .invalid(invalid)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    logic [6:0] gl [16] = '{7'b1111111, 7'b0001000, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b1000000, 7'b1100001,
                            7'b0011000, 7'b0001001, 7'b1111111, 7'b1111111};

    int n_chk = 0;
    int n_pass = 0;
    int hand[$];
    int bt = 0;
    bit m_ovf, m_inv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int m_score();
        int s = 0;
        foreach (hand[i]) s += hand[i] <= 9 ? hand[i] : 0;
        return s % 10;
    endfunction

    function automatic logic [7*NS-1:0] m_hex();
        logic [7*NS-1:0] h;
        bit blank = blink_en && hand.size() > 0 && (bt / BH) % 2 == 1;
        for (int i = 0; i < NS; i++)
            h[7*i +: 7] = i >= hand.size() ? gl[0] : (blank && i == hand.size() - 1) ? 7'b1111111 : gl[hand[i]];
        return h;
    endfunction

    task automatic step(input logic ld, input logic [3:0] c, input logic clr, input logic rb, input logic be);
        bit acc = 0;
        load = ld; card_in = c; clear = clr; resetb = rb; blink_en = be;
        @(posedge slow_clock);
        m_ovf = 0; m_inv = 0;
        if (!rb || clr) begin
            hand.delete();
            bt = 0;
        end else begin
            if (ld) begin
                if (c == 0 || c > 13) m_inv = 1;
                else if (hand.size() == NS) m_ovf = 1;
                else begin
                    acc = 1;
                    bt = 0;
                end
            end
            bt = (acc || !be || hand.size() == 0) ? 0 : bt + 1;
            if (acc) hand.push_back(int'(c));
        end
        #1;
        chk("hex", 32'(hex_out), 32'(m_hex()));
        chk("score", 32'(score), 32'(m_score()));
        chk("count", 32'(count), 32'(hand.size()));
        chk("full", 32'(full), 32'(hand.size() == NS));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("invalid", 32'(invalid), 32'(m_inv));
    endtask

    initial begin
        step(0, 0, 0, 0, 0);
        chk("rst_hex", 32'(hex_out), 32'h1fffff);
        step(1, 7, 0, 1, 0);
        step(1, 8, 0, 1, 0);
        chk("t2_slot0", 32'(hex_out[6:0]), 32'b1111000);
        chk("t2_slot1", 32'(hex_out[13:7]), 32'b0000000);
        chk("t2_score", 32'(score), 32'd5);
        step(1, 13, 0, 1, 0);
        chk("t3_slot2", 32'(hex_out[20:14]), 32'b0001001);
        chk("t3_full", 32'(full), 32'd1);
        step(1, 4, 0, 1, 0);
        chk("t3_ovf", 32'(overflow), 32'd1);
        step(0, 0, 0, 1, 0);
        chk("t3_ovf_clr", 32'(overflow), 32'd0);
        step(1, 0, 0, 1, 0);
        chk("t4_inv0", 32'(invalid), 32'd1);
        step(1, 15, 0, 1, 0);
        chk("t4_inv15", 32'(invalid), 32'd1);
        step(0, 0, 1, 1, 1);
        step(1, 9, 0, 1, 1);
        for (int k = 2; k <= 5; k++) step(0, 0, 0, 1, 1);
        chk("t5_blank", 32'(hex_out[6:0]), 32'b1111111);
        step(1, 2, 0, 1, 1);
        chk("t5_slot0", 32'(hex_out[6:0]), 32'b0010000);
        chk("t5_slot1", 32'(hex_out[13:7]), 32'b0100100);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 1);
        step(1, 5, 1, 1, 1);
        chk("t6_count", 32'(count), 32'd0);
        step(1, 3, 0, 1, 1);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 1);
        step(1, 5, 0, 0, 1);
        chk("t6_rst_hex", 32'(hex_out), 32'h1fffff);
        for (int k = 0; k < 3000; k++) begin
            logic be = blink_en;
            if ($urandom_range(0, 29) == 0) be = ~be;
            step($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom_range(0, 24) == 0,
                 $urandom_range(0, 59) != 0, be);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
